inst_fetch_ctrl: RTL

Fetch sequencer in front of the combinational, byte-addressed, little-endian instruction memory. Owns the fetch PC, drives the memory address every cycle, captures each returned 32-bit word with its PC into a small prefetch FIFO, and presents instructions to decode over a valid/ready handshake. Handles control-flow redirects (flush plus refetch), misaligned-PC faults and out-of-range faults.

---
 rtl/inst_fetch_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, drives a combinational
// instruction memory, buffers fetched words with their PCs in a small
// prefetch FIFO and hands them to decode over valid/ready. Redirects flush
// the FIFO and restart fetching. Misaligned or out-of-range PCs park the
// controller in an error state until a legal redirect or reset.
module inst_fetch_ctrl #(
  parameter int unsigned               MEM_ADDR_WIDTH = 32,
  parameter int unsigned               INST_WIDTH     = 32,
  parameter int unsigned               INST_MEM_SIZE  = 1024,
  parameter logic [MEM_ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter int unsigned               FIFO_DEPTH     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [INST_WIDTH-1:0]     i_mem_data,
  input  logic                      i_redirect,
  input  logic [MEM_ADDR_WIDTH-1:0] i_redirect_pc,
  output logic                      o_inst_valid,
  output logic [INST_WIDTH-1:0]     o_inst,
  output logic [MEM_ADDR_WIDTH-1:0] o_inst_pc,
  input  logic                      i_inst_ready,
  output logic                      o_fetch_err,
  output logic [MEM_ADDR_WIDTH-1:0] o_err_pc
);

  localparam int unsigned IdxW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  // Highest legal fetch PC, held at 64 bits so the comparison never wraps.
  localparam logic [63:0] LastPc = 64'(INST_MEM_SIZE) - 64'd4;

  typedef enum logic [0:0] {
    StRun,
    StErr
  } state_e;

  state_e                      state_q, state_d;
  logic [MEM_ADDR_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [MEM_ADDR_WIDTH-1:0]   err_pc_q, err_pc_d;
  logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [INST_WIDTH-1:0]       data_q [FIFO_DEPTH];
  logic [MEM_ADDR_WIDTH-1:0]   pc_q   [FIFO_DEPTH];

  logic fifo_empty;
  logic fifo_full;
  logic fetch_in_range;
  logic redirect_ok;
  logic push;
  logic pop;

  // FIFO status from the wrap-bit pointer pair.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[IdxW] != rd_ptr_q[IdxW]) &&
                 (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]);
  end

  // Legality checks for the current fetch PC and for a redirect target.
  always_comb begin
    fetch_in_range = (64'(fetch_pc_q) <= LastPc);
    redirect_ok    = (i_redirect_pc[1:0] == 2'b00) && (64'(i_redirect_pc) <= LastPc);
  end

  // Handshake decode; a redirect suppresses both push and pop.
  always_comb begin
    pop  = !fifo_empty && i_inst_ready && !i_redirect;
    push = !i_redirect && (state_q == StRun) && fetch_in_range && (!fifo_full || pop);
  end

  // Next-state logic: redirect first, then per-state fetch sequencing.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    err_pc_d   = err_pc_q;
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);

    if (i_redirect) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      if (redirect_ok) begin
        state_d    = StRun;
        fetch_pc_d = i_redirect_pc;
      end else begin
        state_d  = StErr;
        err_pc_d = i_redirect_pc;
      end
    end else begin
      unique case (state_q)
        StRun: begin
          if (!fetch_in_range) begin
            // Fetch PC ran off the end (or wrapped): stop; queued work drains.
            state_d  = StErr;
            err_pc_d = fetch_pc_q;
          end else if (push) begin
            fetch_pc_d = fetch_pc_q + MEM_ADDR_WIDTH'(4);
          end
        end
        StErr: begin
          // Fetch PC holds; only a redirect or reset leaves this state.
        end
        default: state_d = StRun;
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRun;
      fetch_pc_q <= RESET_PC;
      err_pc_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      err_pc_q   <= err_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Prefetch storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
    end else if (push) begin
      data_q[wr_ptr_q[IdxW-1:0]] <= i_mem_data;
      pc_q[wr_ptr_q[IdxW-1:0]]   <= fetch_pc_q;
    end
  end

  // Outputs; the error flag waits until decode has drained the FIFO.
  always_comb begin
    o_mem_addr   = fetch_pc_q;
    o_inst_valid = !fifo_empty;
    o_inst       = data_q[rd_ptr_q[IdxW-1:0]];
    o_inst_pc    = pc_q[rd_ptr_q[IdxW-1:0]];
    o_fetch_err  = (state_q == StErr) && fifo_empty;
    o_err_pc     = err_pc_q;
  end

endmodule
